ldl_crc32_fcs_inserter: RTL and testbench
=========================================

// Module: ldl_crc32_fcs_inserter
// PURPOSE
//  Sequences the byte-wide CRC-32 datapath (ldl_crc32_d8) over a framed byte stream.
//  Frame bytes pass through to the output unchanged. After the last payload byte the
//  block appends the 4-byte Ethernet FCS. Sits in the MAC TX path, upstream of the PHY.
// PARAMETERS
//  CRC_INIT  32'hFFFF_FFFF  value loaded into the CRC register at reset and at frame start
//  XOR_OUT   32'hFFFF_FFFF  final XOR applied to the bit-reversed CRC to form the FCS
//  CNT_W     16             width of frame_cnt
// PORTS
//  clk        in   1      clock; all state changes on the rising edge
//  rst        in   1      synchronous reset, active-high
//  s_valid    in   1      input byte valid
//  s_ready    out  1      input byte accepted when s_valid & s_ready
//  s_data     in   8      input byte
//  s_last     in   1      marks the last payload byte of the frame
//  m_valid    out  1      output byte valid
//  m_ready    in   1      downstream ready
//  m_data     out  8      output byte (payload or FCS)
//  m_last     out  1      asserted on the final FCS byte only
//  fcs_out    out  32     FCS of the most recently completed frame
//  fcs_valid  out  1      1-cycle pulse when the final FCS byte is accepted
//  busy       out  1      1 while a frame is in progress (state != IDLE)
//  frame_cnt  out  CNT_W  completed frames; saturates at all-ones
// BEHAVIOUR
//  Reset values: state=IDLE, crc=CRC_INIT, cnt=0, fcs_out=0, fcs_valid=0, frame_cnt=0.
//   m_valid/s_ready follow the pass-through rule below (m_valid=s_valid, s_ready=m_ready).
//  Datapath: ldl_crc32_d8 with data_in=bitrev8(s_data) and crc_in=crc register; output crc_next.
//   fcs_calc = bitrev32(crc_next) ^ XOR_OUT. FCS bytes go out LSB first: fcs[7:0] first.
//  States:
//   IDLE/DATA (pass-through, zero latency):
//    m_valid=s_valid, m_data=s_data, m_last=0, s_ready=m_ready.
//   FCS:
//    s_ready=0, m_valid=1, m_data=fcs byte[cnt], m_last=(cnt==3).
//  Byte accept (s_valid & s_ready, in IDLE or DATA):
//    crc<=crc_next.
//    If s_last=0: go to DATA.
//    If s_last=1: go to FCS, cnt<=0, fcs_out<=fcs_calc.
//    A 1-byte frame goes from IDLE straight to FCS.
//  FCS byte accept (m_ready): cnt<=cnt+1. On cnt==3 accepted:
//    go to IDLE, crc<=CRC_INIT, fcs_valid<=1 for one cycle, frame_cnt+=1 (saturating).
//  The next frame's first byte is accepted no earlier than the cycle after the last FCS byte.
//   No bubble beyond that: back-to-back frames run at 1 byte/cycle plus 4 FCS cycles.
//  m_valid stall rule: once m_valid=1 in FCS, m_data/m_last stay stable until m_ready.
//  s_valid may drop mid-frame (gaps allowed). The crc register holds during gaps.
//  fcs_out holds its value until the next frame's s_last is accepted.
//  s_last with s_valid=0 is ignored.
//  rst takes effect in any state including mid-FCS: the frame is dropped, with no
//   fcs_valid and no frame_cnt increment. Output is back in pass-through the next cycle.
// TESTING
//  1 ASCII "123456789" (31..39), s_last on 0x39, m_ready=1:
//    -> output is the 9 bytes, then 26 39 F4 CB with m_last on CB;
//    -> fcs_out=32'hCBF43926; fcs_valid pulses once; frame_cnt=1.
//  2 Single byte 0x00 with s_last:
//    -> IDLE straight to FCS; output 00 8D EF 02 D2; fcs_out=32'hD202EF8D.
//  3 Frame 1 repeated with m_ready toggling 1/0 every cycle and random s_valid gaps:
//    -> same output byte sequence and FCS;
//    -> s_ready=0 throughout FCS; m_data stable while stalled.
//  4 Two back-to-back frames (frame 1, then frame 2):
//    -> second FCS equals the standalone result;
//    -> no extra idle cycle between frames; frame_cnt=2.
//  5 rst pulsed while cnt==2 in FCS, then frame 1 sent:
//    -> no fcs_valid for the aborted frame; frame_cnt=0 after reset;
//    -> new frame yields CBF43926 (crc restarted from CRC_INIT).
//  6 Force frame_cnt to all-ones, complete one frame -> frame_cnt stays all-ones.

Source files
------------

// File: rtl/ldl_crc32_fcs_inserter.sv
// Ethernet FCS inserter: passes frame bytes through and appends the
// 4-byte CRC-32 FCS after the last payload byte.

module ldl_crc32_d8 (
  input  logic [7:0]  data_in,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic [31:0] c;
  logic        fb;

  // MSB-first shift of eight data bits through the CRC-32 LFSR
  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ data_in[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    crc_next = c;
  end

endmodule

module ldl_crc32_fcs_inserter #(
  parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF,
  parameter logic [31:0] XOR_OUT  = 32'hFFFF_FFFF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic [31:0]      fcs_out,
  output logic             fcs_valid,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    FCS  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      fcs_q, fcs_d;
  logic             fcs_valid_q, fcs_valid_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [7:0]  data_rev;
  logic [31:0] crc_next;
  logic [31:0] fcs_calc;
  logic [7:0]  fcs_byte;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) bitrev8[i] = v[7-i];
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    for (int i = 0; i < 32; i++) bitrev32[i] = v[31-i];
  endfunction

  assign data_rev = bitrev8(s_data);

  ldl_crc32_d8 u_crc (
    .data_in  (data_rev),
    .crc_in   (crc_q),
    .crc_next (crc_next)
  );

  assign fcs_calc = bitrev32(crc_next) ^ XOR_OUT;

  // FCS leaves least-significant byte first
  always_comb begin
    fcs_byte = fcs_q[7:0];
    unique case (cnt_q)
      2'd0: fcs_byte = fcs_q[7:0];
      2'd1: fcs_byte = fcs_q[15:8];
      2'd2: fcs_byte = fcs_q[23:16];
      2'd3: fcs_byte = fcs_q[31:24];
      default: fcs_byte = fcs_q[7:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    fcs_d       = fcs_q;
    fcs_valid_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    m_valid     = s_valid;
    m_data      = s_data;
    m_last      = 1'b0;
    s_ready     = m_ready;
    unique case (state_q)
      IDLE, DATA: begin
        if (s_valid && m_ready) begin
          crc_d = crc_next;
          if (s_last) begin
            state_d = FCS;
            cnt_d   = 2'd0;
            fcs_d   = fcs_calc;
          end else begin
            state_d = DATA;
          end
        end
      end
      FCS: begin
        s_ready = 1'b0;
        m_valid = 1'b1;
        m_data  = fcs_byte;
        m_last  = (cnt_q == 2'd3);
        if (m_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d     = IDLE;
            crc_d       = CRC_INIT;
            fcs_valid_d = 1'b1;
            if (frame_cnt_q != {CNT_W{1'b1}})
              frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= CRC_INIT;
      cnt_q       <= 2'd0;
      fcs_q       <= 32'd0;
      fcs_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      fcs_q       <= fcs_d;
      fcs_valid_q <= fcs_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fcs_out   = fcs_q;
  assign fcs_valid = fcs_valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ldl_crc32_fcs_inserter.sv
// Directed bench for ldl_crc32_fcs_inserter: vector table plus
// stream sequences for stalls, back-to-back frames, reset and saturation.

module tb_ldl_crc32_fcs_inserter;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_last;
  logic [7:0]  s_data;
  logic        m_valid, m_ready, m_last;
  logic [7:0]  m_data;
  logic [31:0] fcs_out;
  logic        fcs_valid, busy;
  logic [15:0] frame_cnt;

  logic        sv2, sr2, sl2, mv2, mr2, ml2, fv2, busy2;
  logic [7:0]  sd2, md2;
  logic [31:0] fo2;
  logic [2:0]  fc2;

  always #5 clk = ~clk;

  ldl_crc32_fcs_inserter dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .fcs_out(fcs_out), .fcs_valid(fcs_valid), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  ldl_crc32_fcs_inserter #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst),
    .s_valid(sv2), .s_ready(sr2), .s_data(sd2), .s_last(sl2),
    .m_valid(mv2), .m_ready(mr2), .m_data(md2), .m_last(ml2),
    .fcs_out(fo2), .fcs_valid(fv2), .busy(busy2),
    .frame_cnt(fc2)
  );

  int n_vec = 0;
  int n_bad = 0;
  int fv_cnt = 0;

  always @(negedge clk) if (fcs_valid) fv_cnt++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        sv;
    logic [7:0]  sd;
    logic        sl;
    logic        mr;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic        er;
    logic        efv;
    logic        chk;
    logic [31:0] efcs;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic sv, logic [7:0] sd, logic sl, logic mr,
                              logic ev, logic [7:0] ed, logic el, logic er,
                              logic efv);
    vec_t v;
    v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
    v.ev = ev; v.ed = ed; v.el = el; v.er = er; v.efv = efv;
    v.chk = 1'b0; v.efcs = '0; v.ecnt = '0;
    return v;
  endfunction

  function automatic vec_t mkc(vec_t v, logic [31:0] f, logic [15:0] c);
    v.chk = 1'b1; v.efcs = f; v.ecnt = c;
    return v;
  endfunction

  typedef logic [7:0] bq_t[$];
  typedef logic       lq_t[$];

  bq_t f1_pl, f1_exp;
  lq_t f1_last, f1_elast, f1_fcs;

  // drive a byte stream and check the output sequence in lock-step
  task automatic stream(input bq_t pl, input lq_t pll, input bq_t ex,
                        input lq_t exl, input lq_t exf, input bit tog,
                        input bit gaps, output int cycles);
    int si = 0;
    int oi = 0;
    cycles = 0;
    while (oi < ex.size()) begin
      @(negedge clk);
      s_valid = (si < pl.size()) && (!gaps || $urandom_range(0, 2) != 0);
      s_data  = (si < pl.size()) ? pl[si] : 8'h00;
      s_last  = (si < pl.size()) ? pll[si] : 1'b0;
      m_ready = tog ? cycles[0] : 1'b1;
      #1;
      if (m_valid) begin
        chk($sformatf("stream_data[%0d]", oi), {23'd0, m_last, m_data},
            {23'd0, exl[oi], ex[oi]});
        if (exf[oi]) chk($sformatf("fcs_sready[%0d]", oi), {31'd0, s_ready}, 32'd0);
      end
      if (s_valid && s_ready) si++;
      if (m_valid && m_ready) oi++;
      @(posedge clk);
      cycles++;
      if (cycles > 300) begin
        chk("stream_timeout", 32'(oi), 32'(ex.size()));
        break;
      end
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] fb1[4];
    logic [7:0] fb2[4];
    int cyc;
    int fv0;
    bq_t pl, ex;
    lq_t pll, exl, exf;

    fb1[0] = 8'h26; fb1[1] = 8'h39; fb1[2] = 8'hF4; fb1[3] = 8'hCB;
    fb2[0] = 8'h8D; fb2[1] = 8'hEF; fb2[2] = 8'h02; fb2[3] = 8'hD2;

    for (int i = 0; i < 9; i++) begin
      f1_pl.push_back(8'h31 + 8'(i));
      f1_last.push_back(i == 8);
      f1_exp.push_back(8'h31 + 8'(i));
      f1_elast.push_back(1'b0);
      f1_fcs.push_back(1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      f1_exp.push_back(fb1[i]);
      f1_elast.push_back(i == 3);
      f1_fcs.push_back(1'b1);
    end

    // frame "123456789" at full rate
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(1, 8'h31 + 8'(i), i == 8, 1, 1, 8'h31 + 8'(i), 0, 1, 0));
    for (int i = 0; i < 4; i++) begin
      if (i == 0)
        tbl.push_back(mkc(mk(0, 0, 0, 1, 1, fb1[i], 0, 0, 0), 32'hCBF43926, 16'd0));
      else
        tbl.push_back(mk(0, 0, 0, 1, 1, fb1[i], i == 3, 0, 0));
    end
    tbl.push_back(mkc(mk(0, 0, 0, 1, 0, 0, 0, 1, 1), 32'hCBF43926, 16'd1));
    // single-byte frame 0x00
    tbl.push_back(mk(1, 8'h00, 1, 1, 1, 8'h00, 0, 1, 0));
    for (int i = 0; i < 4; i++) begin
      if (i == 0)
        tbl.push_back(mkc(mk(0, 0, 0, 1, 1, fb2[i], 0, 0, 0), 32'hD202EF8D, 16'd1));
      else
        tbl.push_back(mk(0, 0, 0, 1, 1, fb2[i], i == 3, 0, 0));
    end
    tbl.push_back(mkc(mk(0, 0, 0, 1, 0, 0, 0, 1, 1), 32'hD202EF8D, 16'd2));
    // s_ready follows m_ready; s_last without s_valid ignored
    tbl.push_back(mk(0, 8'hAA, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'hAA, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 8'h55, 0, 0, 1, 8'h55, 0, 0, 0));
    tbl.push_back(mkc(mk(0, 0, 0, 1, 0, 0, 0, 1, 0), 32'hD202EF8D, 16'd2));

    rst = 1'b1; s_valid = 0; s_data = 0; s_last = 0; m_ready = 1;
    sv2 = 0; sd2 = 0; sl2 = 0; mr2 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_fcs_out", fcs_out, 32'd0);
    chk("rst_ctl", {28'd0, busy, fcs_valid, m_valid, s_ready}, 32'h1);

    foreach (tbl[k]) begin
      @(negedge clk);
      s_valid = tbl[k].sv; s_data = tbl[k].sd;
      s_last = tbl[k].sl; m_ready = tbl[k].mr;
      #1;
      chk($sformatf("vec%0d", k),
          {20'd0, m_valid, (tbl[k].ev ? m_data : 8'h00),
           (tbl[k].ev ? m_last : 1'b0), s_ready, fcs_valid},
          {20'd0, tbl[k].ev, tbl[k].ed, tbl[k].el, tbl[k].er, tbl[k].efv});
      if (tbl[k].chk) begin
        chk($sformatf("vec%0d_fcs", k), fcs_out, tbl[k].efcs);
        chk($sformatf("vec%0d_cnt", k), {16'd0, frame_cnt}, {16'd0, tbl[k].ecnt});
      end
    end
    chk("fv_pulses_t12", 32'(fv_cnt), 32'd2);

    // stalls and gaps
    fv0 = fv_cnt;
    stream(f1_pl, f1_last, f1_exp, f1_elast, f1_fcs, 1'b1, 1'b1, cyc);
    #1;
    chk("t3_fcs_out", fcs_out, 32'hCBF43926);
    chk("t3_cnt", {16'd0, frame_cnt}, 32'd3);
    chk("t3_fv", 32'(fv_cnt - fv0), 32'd1);

    // back-to-back frames
    pl = f1_pl; pll = f1_last; ex = f1_exp; exl = f1_elast; exf = f1_fcs;
    pl.push_back(8'h00); pll.push_back(1'b1);
    ex.push_back(8'h00); exl.push_back(1'b0); exf.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      ex.push_back(fb2[i]); exl.push_back(i == 3); exf.push_back(1'b1);
    end
    fv0 = fv_cnt;
    stream(pl, pll, ex, exl, exf, 1'b0, 1'b0, cyc);
    #1;
    chk("t4_cycles", 32'(cyc), 32'd18);
    chk("t4_fcs_out", fcs_out, 32'hD202EF8D);
    chk("t4_cnt", {16'd0, frame_cnt}, 32'd5);
    chk("t4_fv", 32'(fv_cnt - fv0), 32'd2);

    // reset while cnt==2 in the FCS phase
    fv0 = fv_cnt;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      s_valid = (i < 9); s_data = 8'h31 + 8'(i); s_last = (i == 8);
      m_ready = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; rst = 1'b1;
    #1;
    chk("t5_pre_rst", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'hF4});
    @(negedge clk);
    rst = 1'b0; m_ready = 1'b1;
    #1;
    chk("t5_post_rst", {16'd0, frame_cnt}, 32'd0);
    chk("t5_post_ctl", {29'd0, busy, m_valid, s_ready}, 32'h1);
    repeat (3) @(negedge clk);
    chk("t5_no_fv", 32'(fv_cnt - fv0), 32'd0);
    stream(f1_pl, f1_last, f1_exp, f1_elast, f1_fcs, 1'b0, 1'b0, cyc);
    #1;
    chk("t5_fcs_out", fcs_out, 32'hCBF43926);
    chk("t5_cnt", {16'd0, frame_cnt}, 32'd1);

    // saturation on a narrow counter
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      sv2 = 1'b1; sd2 = 8'h00; sl2 = 1'b1; mr2 = 1'b1;
      @(negedge clk);
      sv2 = 1'b0; sl2 = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat_cnt%0d", k), {29'd0, fc2}, (k > 7) ? 32'd7 : 32'(k));
    end
    chk("sat_fcs", fo2, 32'hD202EF8D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
